// File: rtl/tone_queue_player.sv
// Queued square-wave tone player: a FIFO of (duration ms, half-period us)
// notes played back-to-back, with rests, abort/flush and queue status.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing playing; pops the head note when the queue is non-empty
// PLAY  | a note is sounding (or resting); timers run
// SKIP  | a note just ended and the head has zero duration; discard such
//       | heads one per cycle, then load the next real note or finish
module tone_queue_player #(
  parameter int CLOCK_HZ         = 10_000_000,
  parameter int DEPTH            = 8,
  parameter int DURATION_WIDTH   = 16,
  parameter int HALFPERIOD_WIDTH = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Push_i,
  input  logic [DURATION_WIDTH-1:0]     Duration_ms_i,
  input  logic [HALFPERIOD_WIDTH-1:0]   HalfPeriod_us_i,
  input  logic                          Abort_i,
  output logic                          SoundWave_o,
  output logic                          Busy_o,
  output logic                          NoteDone_o,
  output logic                          QueueDone_o,
  output logic                          Full_o,
  output logic                          Empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    Count_o,
  output logic                          Overflow_o
);

  localparam int DIV  = CLOCK_HZ / 1_000_000;
  localparam int US_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PLAY, SKIP} state_t;

  state_t state_q, state_d;

  logic [DURATION_WIDTH-1:0]   dur_mem [DEPTH];
  logic [HALFPERIOD_WIDTH-1:0] hp_mem  [DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count_d;
  logic [DURATION_WIDTH-1:0]   head_dur;
  logic [HALFPERIOD_WIDTH-1:0] head_hp;

  logic [US_W-1:0]             us_cnt;
  logic [9:0]                  ms_cnt;
  logic [DURATION_WIDTH-1:0]   dur_cnt;
  logic [HALFPERIOD_WIDTH-1:0] hp_cnt, hp_reg;
  logic                        wave_q, wave_d;

  logic push_acc, pop, load, note_done_d, queue_done_d;
  logic us_tick, ms_tick, note_end, hp_hit;

  assign head_dur = dur_mem[rd_ptr];
  assign head_hp  = hp_mem[rd_ptr];

  // Abort wins over a same-cycle push; a full queue never accepts, even with a pop.
  assign push_acc = Push_i && !Full_o && !Abort_i;
  assign count_d  = Abort_i ? '0 : Count_o + CW'(push_acc) - CW'(pop);

  assign us_tick  = (state_q == PLAY) && (us_cnt == US_W'(DIV - 1));
  assign ms_tick  = us_tick && (ms_cnt == 10'd999);
  assign note_end = ms_tick && (dur_cnt == DURATION_WIDTH'(1));
  assign hp_hit   = us_tick && (hp_reg != '0) &&
                    (hp_cnt == hp_reg - HALFPERIOD_WIDTH'(1));

  // Next-state, pop/load strobes, done pulses and next wave level.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load         = 1'b0;
    note_done_d  = 1'b0;
    queue_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Empty_o) begin
          pop = 1'b1;
          if (head_dur == '0) begin
            note_done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = PLAY;
          end
        end
      end
      PLAY: begin
        if (note_end) begin
          note_done_d = 1'b1;
          if (Empty_o) begin
            state_d      = IDLE;
            queue_done_d = 1'b1;
          end else if (head_dur != '0) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (Empty_o) begin
          state_d      = IDLE;
          queue_done_d = 1'b1;
        end else begin
          pop = 1'b1;
          if (head_dur == '0) begin
            note_done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = PLAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (Abort_i) begin
      state_d      = IDLE;
      pop          = 1'b0;
      load         = 1'b0;
      note_done_d  = 1'b0;
      queue_done_d = 1'b0;
    end
    wave_d = wave_q;
    if (load || state_d != PLAY) begin
      wave_d = 1'b0;
    end else if (hp_hit) begin
      wave_d = ~wave_q;
    end
  end

  // Note storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge Clock) begin
    if (push_acc) begin
      dur_mem[wr_ptr] <= Duration_ms_i;
      hp_mem[wr_ptr]  <= HalfPeriod_us_i;
    end
  end

  // FIFO pointers, occupancy flags and overflow pulse.
  always_ff @(posedge Clock) begin
    if (!Reset || Abort_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Count_o    <= '0;
      Empty_o    <= 1'b1;
      Full_o     <= 1'b0;
      Overflow_o <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      Count_o    <= count_d;
      Empty_o    <= (count_d == '0);
      Full_o     <= (count_d == CW'(DEPTH));
      Overflow_o <= Push_i && Full_o;
    end
  end

  // us/ms prescalers, duration down-counter and half-period timer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      us_cnt  <= '0;
      ms_cnt  <= '0;
      dur_cnt <= '0;
      hp_cnt  <= '0;
      hp_reg  <= '0;
    end else if (load) begin
      us_cnt  <= '0;
      ms_cnt  <= '0;
      hp_cnt  <= '0;
      dur_cnt <= head_dur;
      hp_reg  <= head_hp;
    end else if (state_q == PLAY) begin
      us_cnt <= us_tick ? '0 : us_cnt + US_W'(1);
      if (us_tick) begin
        ms_cnt <= ms_tick ? '0 : ms_cnt + 10'd1;
        hp_cnt <= hp_hit ? '0 : hp_cnt + HALFPERIOD_WIDTH'(1);
        if (ms_tick) dur_cnt <= dur_cnt - DURATION_WIDTH'(1);
      end
    end
  end

  // State register and registered playback outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wave_q      <= 1'b0;
      Busy_o      <= 1'b0;
      SoundWave_o <= 1'b0;
      NoteDone_o  <= 1'b0;
      QueueDone_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      wave_q      <= wave_d;
      Busy_o      <= (state_d != IDLE);
      SoundWave_o <= wave_d && (state_d != IDLE);
      NoteDone_o  <= note_done_d;
      QueueDone_o <= queue_done_d;
    end
  end

endmodule

// File: tb/tb_tone_queue_player.sv
// Scoreboard bench for tone_queue_player: stimulus queues expected output
// events (wave edges, done/overflow pulses) by edge number; a monitor pops
// and compares them as the DUT produces them.
module tb_tone_queue_player;

  localparam int CLOCK_HZ = 2_000_000;
  localparam int DIV      = 2;
  localparam int DEPTH    = 4;
  localparam int DW       = 16;
  localparam int HW       = 16;

  localparam int K_RISE = 0, K_FALL = 1, K_ND = 2, K_QD = 3, K_OVF = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Push_i = 1'b0;
  logic [DW-1:0] Duration_ms_i = '0;
  logic [HW-1:0] HalfPeriod_us_i = '0;
  logic          Abort_i = 1'b0;
  logic          SoundWave_o, Busy_o, NoteDone_o, QueueDone_o;
  logic          Full_o, Empty_o, Overflow_o;
  logic [2:0]    Count_o;

  tone_queue_player #(
    .CLOCK_HZ(CLOCK_HZ), .DEPTH(DEPTH),
    .DURATION_WIDTH(DW), .HALFPERIOD_WIDTH(HW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Push_i(Push_i),
    .Duration_ms_i(Duration_ms_i), .HalfPeriod_us_i(HalfPeriod_us_i),
    .Abort_i(Abort_i), .SoundWave_o(SoundWave_o), .Busy_o(Busy_o),
    .NoteDone_o(NoteDone_o), .QueueDone_o(QueueDone_o), .Full_o(Full_o),
    .Empty_o(Empty_o), .Count_o(Count_o), .Overflow_o(Overflow_o)
  );

  always #5 Clock = ~Clock;

  int edge_n = 0;
  always @(posedge Clock) edge_n <= edge_n + 1;

  typedef struct {int cyc; int kind;} ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "wave_rise";
      K_FALL:  return "wave_fall";
      K_ND:    return "note_done";
      K_QD:    return "queue_done";
      default: return "overflow";
    endcase
  endfunction

  // Sorted insert keeps the queue in (edge, kind) order, matching the monitor.
  function automatic void push_exp(input int cyc, input int kind);
    ev_t e;
    int  i;
    e.cyc  = cyc;
    e.kind = kind;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < cyc || (exp_q[i].cyc == cyc && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endfunction

  // Expected events of a note (D ms, H us) loaded at edge L.
  function automatic void expect_note(input int L, input int D, input int H, input bit last);
    int endc;
    int lvl;
    endc = L + D * 1000 * DIV;
    lvl  = 0;
    if (H != 0)
      for (int t = L + H * DIV; t < endc; t += H * DIV) begin
        lvl ^= 1;
        push_exp(t, lvl != 0 ? K_RISE : K_FALL);
      end
    if (lvl != 0) push_exp(endc, K_FALL);
    push_exp(endc, K_ND);
    if (last) push_exp(endc, K_QD);
  endfunction

  task automatic got(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %s at edge %0d, expected none", kname(kind), edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != edge_n || e.kind != kind) begin
        errors++;
        $display("FAIL event got %s at edge %0d, expected %s at edge %0d",
                 kname(kind), edge_n, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: watch outputs mid-cycle and match each event against the scoreboard.
  bit prev_snd = 1'b0;
  always @(negedge Clock) begin
    if (SoundWave_o !== prev_snd) begin
      got(SoundWave_o === 1'b1 ? K_RISE : K_FALL);
      prev_snd = (SoundWave_o === 1'b1);
    end
    if (NoteDone_o === 1'b1)  got(K_ND);
    if (QueueDone_o === 1'b1) got(K_QD);
    if (Overflow_o === 1'b1)  got(K_OVF);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_edge(input int t);
    while (edge_n < t) tick();
  endtask

  task automatic push_note(input int d, input int h);
    Push_i          = 1'b1;
    Duration_ms_i   = DW'(d);
    HalfPeriod_us_i = HW'(h);
    tick();
    Push_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sound"}, 32'(SoundWave_o), 0);
    check({tag, "_busy"},  32'(Busy_o), 0);
    check({tag, "_nd"},    32'(NoteDone_o), 0);
    check({tag, "_qd"},    32'(QueueDone_o), 0);
    check({tag, "_full"},  32'(Full_o), 0);
    check({tag, "_empty"}, 32'(Empty_o), 1);
    check({tag, "_count"}, 32'(Count_o), 0);
    check({tag, "_ovf"},   32'(Overflow_o), 0);
  endtask

  int n, L, E, A, R;
  int d_tab[6]  = '{1, 1, 1, 1, 1, 1};
  int h_tab[6]  = '{0, 500, 0, 250, 0, 100};
  int hr_tab[3] = '{100, 125, 250};

  initial begin
    repeat (3) tick();
    check_reset_vals("reset");
    Reset = 1'b1;

    // Single note into an idle block.
    n = edge_n + 1;
    expect_note(n + 1, 3, 250, 1'b1);
    push_note(3, 250);
    check("t1_count_after_push", 32'(Count_o), 1);
    check("t1_busy_after_push", 32'(Busy_o), 0);
    tick();
    check("t1_busy_after_pop", 32'(Busy_o), 1);
    check("t1_count_after_pop", 32'(Count_o), 0);
    wait_edge(n + 1 + 6000);
    check("t1_busy_after_end", 32'(Busy_o), 0);
    tick();

    // Three queued notes including a rest.
    n = edge_n + 1;
    L = n + 1;
    expect_note(L, 2, 100, 1'b0);
    expect_note(L + 4000, 1, 0, 1'b0);
    expect_note(L + 6000, 2, 50, 1'b1);
    push_note(2, 100);
    push_note(1, 0);
    push_note(2, 50);
    wait_edge(L + 5000);
    check("t2_busy_mid_rest", 32'(Busy_o), 1);
    check("t2_sound_mid_rest", 32'(SoundWave_o), 0);
    wait_edge(L + 10000 + 2);

    // Fill to full, then one dropped push.
    n = edge_n + 1;
    L = n + 1;
    for (int i = 0; i < 5; i++) expect_note(L + 2000 * i, d_tab[i], h_tab[i], i == 4);
    push_exp(n + 5, K_OVF);
    for (int i = 0; i < 6; i++) begin
      push_note(d_tab[i], h_tab[i]);
      if (i >= 4) begin
        check("t3_full", 32'(Full_o), 1);
        check("t3_count", 32'(Count_o), 4);
      end
    end
    wait_edge(L + 10000 + 2);

    // Zero-duration head from idle, then pointer wrap rounds.
    n = edge_n + 1;
    push_exp(n + 1, K_ND);
    expect_note(n + 2, 1, 100, 1'b1);
    push_note(0, 100);
    push_note(1, 100);
    wait_edge(n + 2 + 2000 + 2);
    for (int r = 0; r < 3; r++) begin
      n = edge_n + 1;
      L = n + 1;
      E = L + 2000;
      expect_note(L, 1, 0, 1'b0);
      push_exp(E + 1, K_ND);
      push_exp(E + 2, K_ND);
      push_exp(E + 3, K_ND);
      expect_note(E + 4, 1, hr_tab[r], 1'b1);
      push_note(1, 0);
      push_note(0, 77);
      push_note(0, 77);
      push_note(0, 77);
      push_note(1, hr_tab[r]);
      check("t4_wrap_full", 32'(Full_o), 1);
      wait_edge(E + 4 + 2000 + 2);
    end

    // Abort mid-note with a full queue and a same-cycle push.
    n = edge_n + 1;
    L = n + 1;
    A = L + 1100;
    for (int k = 1; k <= 5; k++) push_exp(L + 200 * k, (k % 2) != 0 ? K_RISE : K_FALL);
    push_exp(A, K_FALL);
    push_note(2, 100);
    for (int i = 0; i < 4; i++) push_note(1, 0);
    check("t5_full_before_abort", 32'(Full_o), 1);
    wait_edge(A - 1);
    Abort_i = 1'b1;
    Push_i  = 1'b1;
    Duration_ms_i   = DW'(1);
    HalfPeriod_us_i = HW'(10);
    tick();
    Abort_i = 1'b0;
    Push_i  = 1'b0;
    check("t5_sound", 32'(SoundWave_o), 0);
    check("t5_busy", 32'(Busy_o), 0);
    check("t5_count", 32'(Count_o), 0);
    check("t5_empty", 32'(Empty_o), 1);
    check("t5_full", 32'(Full_o), 0);
    wait_edge(A + 4500);

    // Reset mid-note, then normal playback.
    n = edge_n + 1;
    L = n + 1;
    R = L + 300;
    push_exp(L + 200, K_RISE);
    push_exp(R, K_FALL);
    push_note(2, 100);
    wait_edge(R - 1);
    Reset = 1'b0;
    tick();
    check_reset_vals("t6");
    tick();
    Reset = 1'b1;
    n = edge_n + 1;
    expect_note(n + 1, 1, 100, 1'b1);
    push_note(1, 100);
    wait_edge(n + 1 + 2000 + 2);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
